gshare_pht: RTL and testbench

Pattern history table for the branch predictor: 2-bit saturating counters indexed by fetch PC hashed with the global history. The global history comes from the upstream `nbit_stp_shiftreg` history register. At fetch it returns a registered taken/not-taken prediction. At branch resolution it trains the addressed counter and produces the enable/bit pair that shifts the resolved outcome into the history register.

---
 rtl/gshare_pht_pkg.sv | 15 +
 rtl/gshare_pht_sat_counter2.sv | 21 ++
 rtl/gshare_pht.sv | 88 ++++++++
 tb/tb_gshare_pht.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pht_pkg.sv
// Shared types and constants for the gshare pattern history table.
// Counter encoding: MSB is the predicted direction.
package gshare_pht_pkg;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t PHT_STRONG_NT = 2'b00;
  localparam pht_cnt_t PHT_WEAK_NT   = 2'b01;
  localparam pht_cnt_t PHT_WEAK_T    = 2'b10;
  localparam pht_cnt_t PHT_STRONG_T  = 2'b11;
  localparam pht_cnt_t PHT_RESET_VAL = PHT_WEAK_NT;

  localparam logic [15:0] MISPRED_MAX = 16'hFFFF;

endpackage

// File: rtl/gshare_pht_sat_counter2.sv
// Combinational next-state function of a 2-bit saturating counter:
// taken counts up to strong-taken, not-taken counts down to strong-not-taken.
module sat_counter2
  import gshare_pht_pkg::*;
(
  input  pht_cnt_t cnt,
  input  logic     taken,
  output pht_cnt_t next
);

  // NOTE: next gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != PHT_STRONG_T) next = pht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != PHT_STRONG_NT) next = pht_cnt_t'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Pattern history table of 2-bit counters with registered prediction, training
// update, history-register feed and saturating mispredict counter.
// Define GSHARE_XOR_EN to hash the PC index with ghr_in (gshare); otherwise bimodal.
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int HIST_BITS    = 3,
  parameter int PHT_IDX_BITS = 6
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    pred_req,
  input  logic [31:0]             pred_pc,
  input  logic [HIST_BITS-1:0]    ghr_in,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [PHT_IDX_BITS-1:0] pred_idx,
  input  logic                    upd_valid,
  input  logic [PHT_IDX_BITS-1:0] upd_idx,
  input  logic                    upd_taken,
  input  logic                    upd_pred_taken,
  output logic                    hist_shift_en,
  output logic                    hist_bit,
  output logic [15:0]             mispred_cnt
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  pht_cnt_t                  pht [PHT_ENTRIES];
  pht_cnt_t                  upd_next;
  logic [PHT_IDX_BITS-1:0]   req_idx;

`ifdef GSHARE_XOR_EN
  logic [PHT_IDX_BITS-1:0] ghr_ext;
  logic                    unused_pc_bits;

  assign ghr_ext        = PHT_IDX_BITS'(ghr_in);
  assign req_idx        = pred_pc[PHT_IDX_BITS+1:2] ^ ghr_ext;
  assign unused_pc_bits = ^{pred_pc[31:PHT_IDX_BITS+2], pred_pc[1:0]};
`else
  logic unused_pc_bits;

  assign req_idx        = pred_pc[PHT_IDX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc[31:PHT_IDX_BITS+2], pred_pc[1:0], ghr_in};
`endif

  assign hist_shift_en = upd_valid;
  assign hist_bit      = upd_taken;

  sat_counter2 u_sat (
    .cnt   (pht[upd_idx]),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // NOTE: the table is plain flops, so every entry is reset; an SRAM could not be.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_RESET_VAL;
    end else if (upd_valid) begin
      pht[upd_idx] <= upd_next;
    end
  end

  // NOTE: non-blocking reads here see the pre-update counter, giving read-before-write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        pred_taken <= pht[req_idx][1];
        pred_idx   <= req_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispred_cnt <= '0;
    end else if (upd_valid && (upd_taken != upd_pred_taken) && (mispred_cnt != MISPRED_MAX)) begin
      mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed vector table, randomized traffic
// against an integer-array reference model, counter saturation and mid-stream reset.
module tb_gshare_pht;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic [2:0]  ghr_in;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic        hist_shift_en;
  logic        hist_bit;
  logic [15:0] mispred_cnt;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  int m_pht [64];
  int m_valid, m_taken, m_idx, m_mis;

  gshare_pht #(.HIST_BITS(3), .PHT_IDX_BITS(6)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .ghr_in         (ghr_in),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .hist_shift_en  (hist_shift_en),
    .hist_bit       (hist_bit),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          req;
    logic [31:0] pc;
    logic [2:0]  ghr;
    bit          uv;
    logic [5:0]  ui;
    bit          ut;
    bit          upt;
    bit          e_valid;
    bit          e_taken;
    logic [5:0]  e_idx;
    logic [15:0] e_mis;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_idx(input logic [31:0] pc, input logic [2:0] ghr);
    int idx;
    idx = (pc / 4) % 64;
`ifdef GSHARE_XOR_EN
    idx = idx ^ int'(ghr);
`endif
    return idx;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_valid = 0; m_taken = 0; m_idx = 0; m_mis = 0;
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), check the
  // combinational history feed, advance the model, and return #1 after the next edge.
  task automatic cycle(input bit req, input logic [31:0] pc, input logic [2:0] ghr,
                       input bit uv, input logic [5:0] ui, input bit ut, input bit upt);
    int idx;
    pred_req = req; pred_pc = pc; ghr_in = ghr;
    upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred_taken = upt;
    #2;
    check("hist_shift_en", 32'(hist_shift_en), 32'(uv));
    check("hist_bit", 32'(hist_bit), 32'(ut));
    m_valid = req;
    if (req) begin
      idx = model_idx(pc, ghr);
      m_idx = idx;
      m_taken = (m_pht[idx] >= 2) ? 1 : 0;
    end
    if (uv) begin
      if (ut) m_pht[ui] = (m_pht[ui] + 1 > 3) ? 3 : m_pht[ui] + 1;
      else    m_pht[ui] = (m_pht[ui] - 1 < 0) ? 0 : m_pht[ui] - 1;
      if (ut != upt && m_mis < 65535) m_mis = m_mis + 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pred_valid"}, 32'(pred_valid), 32'(m_valid));
    check({tag, " pred_taken"}, 32'(pred_taken), 32'(m_taken));
    check({tag, " pred_idx"}, 32'(pred_idx), 32'(m_idx));
    check({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(m_mis));
  endtask

  initial begin
    logic [5:0] e12_idx;
    int n;
`ifdef GSHARE_XOR_EN
    e12_idx = 6'h00;
`else
    e12_idx = 6'h05;
`endif
    //          req pc      ghr   uv ui    ut upt  valid taken idx    mis
    vt[0]  = '{1, 32'h100, 3'd0, 0, 6'd0, 0, 0,   1, 0, 6'h00, 16'd0};
    vt[1]  = '{0, 32'h0,   3'd0, 1, 6'd5, 1, 0,   0, 0, 6'h00, 16'd1};
    vt[2]  = '{0, 32'h0,   3'd0, 1, 6'd5, 1, 1,   0, 0, 6'h00, 16'd1};
    vt[3]  = '{1, 32'h14,  3'd0, 0, 6'd0, 0, 0,   1, 1, 6'h05, 16'd1};
    vt[4]  = '{0, 32'h0,   3'd0, 1, 6'd5, 1, 1,   0, 1, 6'h05, 16'd1};
    vt[5]  = '{0, 32'h0,   3'd0, 1, 6'd5, 1, 1,   0, 1, 6'h05, 16'd1};
    vt[6]  = '{1, 32'h14,  3'd0, 0, 6'd0, 0, 0,   1, 1, 6'h05, 16'd1};
    vt[7]  = '{0, 32'h0,   3'd0, 1, 6'd5, 0, 1,   0, 1, 6'h05, 16'd2};
    vt[8]  = '{0, 32'h0,   3'd0, 1, 6'd5, 0, 1,   0, 1, 6'h05, 16'd3};
    vt[9]  = '{1, 32'h14,  3'd0, 0, 6'd0, 0, 0,   1, 0, 6'h05, 16'd3};
    vt[10] = '{1, 32'h24,  3'd0, 1, 6'd9, 1, 0,   1, 0, 6'h09, 16'd4};
    vt[11] = '{1, 32'h24,  3'd0, 0, 6'd0, 0, 0,   1, 1, 6'h09, 16'd4};
    vt[12] = '{1, 32'h14,  3'd5, 0, 6'd0, 0, 0,   1, 0, e12_idx, 16'd4};

    nRST = 1'b0;
    pred_req = 0; pred_pc = 0; ghr_in = 0;
    upd_valid = 0; upd_idx = 0; upd_taken = 0; upd_pred_taken = 0;
    model_reset();
    #12 nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_model("reset");

    // Directed table
    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].req, vt[i].pc, vt[i].ghr, vt[i].uv, vt[i].ui, vt[i].ut, vt[i].upt);
      check($sformatf("vec%0d pred_valid", i), 32'(pred_valid), 32'(vt[i].e_valid));
      check($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vt[i].e_taken));
      check($sformatf("vec%0d pred_idx", i), 32'(pred_idx), 32'(vt[i].e_idx));
      check($sformatf("vec%0d mispred_cnt", i), 32'(mispred_cnt), 32'(vt[i].e_mis));
    end

    // Randomized traffic; a narrow index range provokes collisions
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      logic [5:0]  ui;
      pc = $urandom();
      if ($urandom_range(1, 0) == 1) pc[31:5] = '0;
      ui = 6'($urandom_range(63, 0));
      if ($urandom_range(1, 0) == 1) ui = 6'($urandom_range(7, 0));
      cycle(1'($urandom_range(1, 0)), pc, 3'($urandom_range(7, 0)),
            1'($urandom_range(1, 0)), ui, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      check_model("rand");
    end

    // Mispredict counter saturation
    n = 65534 - m_mis;
    pred_req = 0; upd_valid = 1; upd_idx = 6'd0; upd_taken = 1; upd_pred_taken = 0;
    repeat (n) @(posedge CLK);
    #1;
    m_mis = 65534; m_valid = 0; m_pht[0] = 3;
    check("mispred near max", 32'(mispred_cnt), 32'(m_mis));
    cycle(0, 32'h0, 3'd0, 1, 6'd0, 1, 0);
    check("mispred at max", 32'(mispred_cnt), 32'hFFFF);
    cycle(0, 32'h0, 3'd0, 1, 6'd0, 1, 0);
    check("mispred saturated", 32'(mispred_cnt), 32'hFFFF);

    // Mid-stream reset after training idx 5 to strong-taken
    repeat (3) cycle(0, 32'h0, 3'd0, 1, 6'd5, 1, 1);
    cycle(1, 32'h14, 3'd0, 0, 6'd0, 0, 0);
    check("pre-reset pred_valid", 32'(pred_valid), 32'd1);
    check("pre-reset pred_taken", 32'(pred_taken), 32'd1);
    nRST = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge CLK);
    nRST = 1'b1;
    pred_req = 0; upd_valid = 0;
    @(posedge CLK);
    #1;
    cycle(1, 32'h14, 3'd0, 0, 6'd0, 0, 0);
    check("post-reset pred_valid", 32'(pred_valid), 32'd1);
    check("post-reset pred_taken", 32'(pred_taken), 32'd0);
    check("post-reset pred_idx", 32'(pred_idx), 32'h05);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
